// File: rtl/sblk_row_dispatch.sv
// Row front-end: buffers tagged instructions per superblock, issues them when the
// superblock is idle, and forwards activation beats through a single register stage.
module sblk_row_dispatch #(
    parameter int N_ROW           = 12,
    parameter int WID_ROW         = $clog2(N_ROW),
    parameter int WID_ACT         = 16,
    parameter int WID_INST        = 14,
    parameter int INST_FIFO_DEPTH = 4,
    parameter int WID_IFIFO       = $clog2(INST_FIFO_DEPTH)
) (
    input  logic                      clk_h,
    input  logic                      rst,
    input  logic [WID_INST-1:0]       inst_in_data,
    input  logic [WID_ROW-1:0]        inst_in_row,
    input  logic                      inst_in_bcast,
    input  logic [N_ROW-1:0]          bcast_mask,
    input  logic                      inst_in_vld,
    output logic                      inst_in_rdy,
    input  logic [2*WID_ACT-1:0]      act_in_data,
    input  logic [WID_ROW-1:0]        act_in_row,
    input  logic                      act_in_vld,
    output logic                      act_in_rdy,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    output logic [2*WID_ACT-1:0]      act_data_out,
    output logic [N_ROW-1:0]          act_data_vld,
    input  logic [N_ROW-1:0]          act_data_req,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic                      row_idle,
    output logic                      err_row
);

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} issue_state_t;

    localparam logic [WID_IFIFO:0]   FIFO_FULL_CNT = (WID_IFIFO+1)'(INST_FIFO_DEPTH);
    localparam logic [WID_IFIFO:0]   CNT_ONE       = (WID_IFIFO+1)'(1);
    localparam logic [WID_IFIFO-1:0] PTR_ONE       = WID_IFIFO'(1);

    logic [N_ROW-1:0] inst_hit;
    logic [N_ROW-1:0] act_hit;
    logic [N_ROW-1:0] fifo_full;
    logic [N_ROW-1:0] fifo_empty;
    logic [N_ROW-1:0] fifo_wr;
    logic [N_ROW-1:0] row_busy;
    logic             inst_in_range;
    logic             act_in_range;
    logic             inst_acc;
    logic             act_acc;
    logic             act_stage_free;

    logic [N_ROW-1:0]     act_vld_q, act_vld_d;
    logic [2*WID_ACT-1:0] act_data_q, act_data_d;
    logic                 err_q, err_d;

    // Tag decode as one-hot compares so out-of-range tags simply hit nothing.
    genvar gi;
    generate
        for (gi = 0; gi < N_ROW; gi++) begin : g_decode
            assign inst_hit[gi] = (inst_in_row == WID_ROW'(gi));
            assign act_hit[gi]  = (act_in_row == WID_ROW'(gi));
        end
    endgenerate

    assign inst_in_range = |inst_hit;
    assign act_in_range  = |act_hit;

    always_comb begin
        inst_in_rdy = 1'b1;
        if (inst_in_bcast) begin
            inst_in_rdy = ~|(bcast_mask & fifo_full);
        end else if (inst_in_range) begin
            inst_in_rdy = ~|(inst_hit & fifo_full);
        end
    end

    assign inst_acc = inst_in_vld & inst_in_rdy;

    always_comb begin
        fifo_wr = '0;
        if (inst_acc) begin
            fifo_wr = inst_in_bcast ? bcast_mask : inst_hit;
        end
    end

    generate
        for (gi = 0; gi < N_ROW; gi++) begin : g_row
            logic [WID_IFIFO-1:0] wr_ptr_q, wr_ptr_d;
            logic [WID_IFIFO-1:0] rd_ptr_q, rd_ptr_d;
            logic [WID_IFIFO:0]   cnt_q, cnt_d;
            logic [WID_INST-1:0]  fifo_mem [INST_FIFO_DEPTH];
            logic [WID_INST-1:0]  fifo_head;
            issue_state_t         state_q, state_d;
            logic                 wait_last_q, wait_last_d;
            logic                 inst_en_q, inst_en_d;
            logic [WID_INST-1:0]  inst_data_q, inst_data_d;
            logic                 can_arb;
            logic                 issue_go;

            assign fifo_head      = fifo_mem[rd_ptr_q];
            assign fifo_full[gi]  = (cnt_q == FIFO_FULL_CNT);
            assign fifo_empty[gi] = (cnt_q == '0);

            // The last WAIT cycle arbitrates like IDLE, giving a 3-cycle issue spacing.
            assign can_arb  = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && wait_last_q);
            assign issue_go = can_arb && !fifo_empty[gi] && !status_sblk[gi];

            always_ff @(posedge clk_h) begin
                if (fifo_wr[gi]) begin
                    fifo_mem[wr_ptr_q] <= inst_in_data;
                end
            end

            always_comb begin
                wr_ptr_d = fifo_wr[gi] ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
                rd_ptr_d = issue_go ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
                cnt_d    = cnt_q;
                if (fifo_wr[gi] && !issue_go) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else if (!fifo_wr[gi] && issue_go) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            always_ff @(posedge clk_h) begin
                if (rst) begin
                    wr_ptr_q    <= '0;
                    rd_ptr_q    <= '0;
                    cnt_q       <= '0;
                    state_q     <= ST_IDLE;
                    wait_last_q <= 1'b0;
                    inst_en_q   <= 1'b0;
                    inst_data_q <= '0;
                end else begin
                    wr_ptr_q    <= wr_ptr_d;
                    rd_ptr_q    <= rd_ptr_d;
                    cnt_q       <= cnt_d;
                    state_q     <= state_d;
                    wait_last_q <= wait_last_d;
                    inst_en_q   <= inst_en_d;
                    inst_data_q <= inst_data_d;
                end
            end

            always_comb begin
                state_d     = state_q;
                wait_last_d = wait_last_q;
                case (state_q)
                    ST_IDLE: begin
                        if (issue_go) begin
                            state_d = ST_ISSUE;
                        end
                    end
                    ST_ISSUE: begin
                        state_d     = ST_WAIT;
                        wait_last_d = 1'b0;
                    end
                    ST_WAIT: begin
                        if (!wait_last_q) begin
                            wait_last_d = 1'b1;
                        end else begin
                            state_d = issue_go ? ST_ISSUE : ST_IDLE;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                    end
                endcase
            end

            always_comb begin
                inst_en_d   = issue_go;
                inst_data_d = issue_go ? fifo_head : inst_data_q;
            end

            assign row_busy[gi]                        = (state_q != ST_IDLE);
            assign inst_en[gi]                         = inst_en_q;
            assign inst_data[gi*WID_INST +: WID_INST]  = inst_data_q;
        end
    endgenerate

    // The held beat leaves the stage in any cycle its target row requests.
    assign act_stage_free = (~|act_vld_q) | (|(act_vld_q & act_data_req));
    assign act_in_rdy     = act_in_range ? ((|(act_hit & act_data_req)) & act_stage_free) : 1'b1;
    assign act_acc        = act_in_vld & act_in_rdy;

    always_comb begin
        act_vld_d  = act_vld_q;
        act_data_d = act_data_q;
        if (act_acc && act_in_range) begin
            act_vld_d  = act_hit;
            act_data_d = act_in_data;
        end else if (act_stage_free) begin
            act_vld_d = '0;
        end
        err_d = err_q
              | (inst_acc & ~inst_in_bcast & ~inst_in_range)
              | (act_acc & ~act_in_range);
    end

    always_ff @(posedge clk_h) begin
        if (rst) begin
            act_vld_q  <= '0;
            act_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            act_vld_q  <= act_vld_d;
            act_data_q <= act_data_d;
            err_q      <= err_d;
        end
    end

    assign act_data_out = act_data_q;
    assign act_data_vld = act_vld_q;
    assign err_row      = err_q;
    assign row_idle     = (&fifo_empty) & ~(|row_busy) & ~(|status_sblk);

endmodule

// File: tb/tb_sblk_row_dispatch.sv
// Directed bench for sblk_row_dispatch: reset, unicast/broadcast issue, activation stall, error tag.
module tb_sblk_row_dispatch;

    localparam int N_ROW    = 12;
    localparam int WID_ROW  = 4;
    localparam int WID_ACT  = 16;
    localparam int WID_INST = 14;

    logic                      clk_h = 1'b0;
    logic                      rst;
    logic [WID_INST-1:0]       inst_in_data;
    logic [WID_ROW-1:0]        inst_in_row;
    logic                      inst_in_bcast;
    logic [N_ROW-1:0]          bcast_mask;
    logic                      inst_in_vld;
    logic                      inst_in_rdy;
    logic [2*WID_ACT-1:0]      act_in_data;
    logic [WID_ROW-1:0]        act_in_row;
    logic                      act_in_vld;
    logic                      act_in_rdy;
    logic [WID_INST*N_ROW-1:0] inst_data;
    logic [N_ROW-1:0]          inst_en;
    logic [2*WID_ACT-1:0]      act_data_out;
    logic [N_ROW-1:0]          act_data_vld;
    logic [N_ROW-1:0]          act_data_req;
    logic [N_ROW-1:0]          status_sblk;
    logic                      row_idle;
    logic                      err_row;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk_h = ~clk_h;

    sblk_row_dispatch #(
        .N_ROW(N_ROW), .WID_ROW(WID_ROW), .WID_ACT(WID_ACT), .WID_INST(WID_INST),
        .INST_FIFO_DEPTH(4), .WID_IFIFO(2)
    ) dut (
        .clk_h(clk_h), .rst(rst),
        .inst_in_data(inst_in_data), .inst_in_row(inst_in_row), .inst_in_bcast(inst_in_bcast),
        .bcast_mask(bcast_mask), .inst_in_vld(inst_in_vld), .inst_in_rdy(inst_in_rdy),
        .act_in_data(act_in_data), .act_in_row(act_in_row), .act_in_vld(act_in_vld),
        .act_in_rdy(act_in_rdy), .inst_data(inst_data), .inst_en(inst_en),
        .act_data_out(act_data_out), .act_data_vld(act_data_vld), .act_data_req(act_data_req),
        .status_sblk(status_sblk), .row_idle(row_idle), .err_row(err_row)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    function automatic logic [WID_INST-1:0] row_data(input int r);
        return inst_data[r*WID_INST +: WID_INST];
    endfunction

    function automatic logic [31:0] beat(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    // Activation stall script: req[9] per cycle, index of beat expected on the stage (-1 = none).
    bit          req_pat [12] = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1};
    int          exp_idx [12] = '{-1, 0, 1, 1, 1, 2, 3, 4, 4, 5, -1, -1};
    logic [31:0] consumed [$];

    initial begin
        logic [63:0] exp_en;
        logic [WID_INST-1:0] exp_d;
        int idx;

        rst = 1'b1;
        inst_in_data = '0; inst_in_row = '0; inst_in_bcast = 1'b0; bcast_mask = '0;
        inst_in_vld = 1'b0; act_in_data = '0; act_in_row = '0; act_in_vld = 1'b0;
        act_data_req = '0; status_sblk = '0;

        // Reset with random inputs
        repeat (3) begin
            inst_in_data = 14'($urandom); inst_in_row = 4'($urandom);
            inst_in_bcast = 1'($urandom); bcast_mask = 12'($urandom);
            inst_in_vld = 1'($urandom); act_in_data = $urandom;
            act_in_row = 4'($urandom); act_in_vld = 1'($urandom);
            act_data_req = 12'($urandom); status_sblk = 12'($urandom);
            tick();
        end
        inst_in_data = '0; inst_in_row = '0; inst_in_bcast = 1'b0; bcast_mask = '0;
        inst_in_vld = 1'b0; act_in_data = '0; act_in_row = '0; act_in_vld = 1'b0;
        act_data_req = '0; status_sblk = '0;
        #1;
        check_eq("rst_inst_en", 64'(inst_en), 64'h0);
        check_eq("rst_inst_data", 64'(|inst_data), 64'h0);
        check_eq("rst_act_vld", 64'(act_data_vld), 64'h0);
        check_eq("rst_act_data", 64'(act_data_out), 64'h0);
        check_eq("rst_err", 64'(err_row), 64'h0);
        check_eq("rst_inst_rdy", 64'(inst_in_rdy), 64'h1);
        check_eq("rst_row_idle", 64'(row_idle), 64'h1);
        rst = 1'b0;
        tick();

        // Unicast flow control on row 3
        status_sblk = 12'h008;
        for (int i = 0; i < 4; i++) begin
            inst_in_data = 14'(14'h101 + i); inst_in_row = 4'd3; inst_in_vld = 1'b1;
            #1;
            $display("[TB] push row=3 data=0x%0h rdy=%0b", inst_in_data, inst_in_rdy);
            check_eq("uni_rdy", 64'(inst_in_rdy), 64'h1);
            tick();
        end
        inst_in_data = 14'h105;
        #1;
        check_eq("uni_full_rdy", 64'(inst_in_rdy), 64'h0);
        check_eq("uni_busy_idle", 64'(row_idle), 64'h0);
        tick();
        inst_in_vld = 1'b0;
        check_eq("uni_blocked_en", 64'(inst_en), 64'h0);
        status_sblk = '0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            exp_en = (k == 1 || k == 4 || k == 7 || k == 10) ? 64'h008 : 64'h0;
            $display("[TB] uni cycle t+%0d inst_en=0x%0h data3=0x%0h", k, inst_en, row_data(3));
            check_eq($sformatf("uni_en_t%0d", k), 64'(inst_en), exp_en);
            if (exp_en != 0) begin
                check_eq($sformatf("uni_data_t%0d", k), 64'(row_data(3)), 64'(14'h101 + (k - 1) / 3));
            end
        end
        check_eq("uni_hold_data", 64'(row_data(3)), 64'h104);
        check_eq("uni_end_idle", 64'(row_idle), 64'h1);

        // Broadcast to rows 4..7
        inst_in_bcast = 1'b1; bcast_mask = 12'h0F0; inst_in_data = 14'h2AA; inst_in_vld = 1'b1;
        #1;
        check_eq("bc_rdy", 64'(inst_in_rdy), 64'h1);
        tick();
        inst_in_vld = 1'b0; inst_in_bcast = 1'b0; bcast_mask = '0;
        check_eq("bc_en_early", 64'(inst_en), 64'h0);
        tick();
        $display("[TB] bcast inst_en=0x%0h", inst_en);
        check_eq("bc_en", 64'(inst_en), 64'h0F0);
        for (int r = 4; r < 8; r++) begin
            check_eq($sformatf("bc_data_r%0d", r), 64'(row_data(r)), 64'h2AA);
        end
        check_eq("bc_other_data", 64'(row_data(3)), 64'h104);
        repeat (3) tick();
        check_eq("bc_idle", 64'(row_idle), 64'h1);

        // Broadcast with empty mask is dropped
        inst_in_bcast = 1'b1; bcast_mask = '0; inst_in_data = 14'h3FF; inst_in_vld = 1'b1;
        #1;
        check_eq("bc0_rdy", 64'(inst_in_rdy), 64'h1);
        tick();
        inst_in_vld = 1'b0; inst_in_bcast = 1'b0;
        tick();
        tick();
        check_eq("bc0_no_en", 64'(inst_en), 64'h0);
        check_eq("bc0_idle", 64'(row_idle), 64'h1);

        // Broadcast blocked by full row 5
        status_sblk = 12'h020;
        for (int i = 0; i < 4; i++) begin
            inst_in_data = 14'(14'h051 + i); inst_in_row = 4'd5; inst_in_vld = 1'b1;
            #1;
            check_eq("blk_fill_rdy", 64'(inst_in_rdy), 64'h1);
            tick();
        end
        inst_in_bcast = 1'b1; bcast_mask = 12'h030; inst_in_data = 14'h3CC;
        #1;
        check_eq("blk_rdy0", 64'(inst_in_rdy), 64'h0);
        tick();
        check_eq("blk_rdy1", 64'(inst_in_rdy), 64'h0);
        check_eq("blk_en0", 64'(inst_en), 64'h0);
        tick();
        check_eq("blk_en1", 64'(inst_en), 64'h0);
        status_sblk = '0;
        for (int k = 1; k <= 13; k++) begin
            tick();
            if (k == 1) check_eq("blk_rdy_after_pop", 64'(inst_in_rdy), 64'h1);
            if (k == 2) begin
                inst_in_vld = 1'b0; inst_in_bcast = 1'b0; bcast_mask = '0;
            end
            case (k)
                1, 4, 7, 10, 13: exp_en = 64'h020;
                3:               exp_en = 64'h010;
                default:         exp_en = 64'h0;
            endcase
            $display("[TB] blk cycle t+%0d inst_en=0x%0h data5=0x%0h", k, inst_en, row_data(5));
            check_eq($sformatf("blk_en_t%0d", k), 64'(inst_en), exp_en);
            case (k)
                1:  exp_d = 14'h051;
                4:  exp_d = 14'h052;
                7:  exp_d = 14'h053;
                10: exp_d = 14'h054;
                13: exp_d = 14'h3CC;
                default: exp_d = '0;
            endcase
            if (exp_en == 64'h020) begin
                check_eq($sformatf("blk_data5_t%0d", k), 64'(row_data(5)), 64'(exp_d));
            end
            if (k == 3) check_eq("blk_data4", 64'(row_data(4)), 64'h3CC);
        end
        repeat (3) tick();

        // Activation stall on row 9
        idx = 0;
        act_in_row = 4'd9;
        for (int c = 0; c < 12; c++) begin
            act_data_req = req_pat[c] ? 12'h200 : 12'h000;
            act_in_vld   = (idx < 6);
            act_in_data  = beat(idx);
            #1;
            $display("[TB] act cycle %0d req=%0b rdy=%0b vld=0x%0h out=0x%0h",
                     c, req_pat[c], act_in_rdy, act_data_vld, act_data_out);
            check_eq($sformatf("act_rdy_c%0d", c), 64'(act_in_rdy), 64'(req_pat[c]));
            check_eq($sformatf("act_vld_c%0d", c), 64'(act_data_vld),
                     (exp_idx[c] >= 0) ? 64'h200 : 64'h0);
            if (exp_idx[c] >= 0) begin
                check_eq($sformatf("act_data_c%0d", c), 64'(act_data_out), 64'(beat(exp_idx[c])));
            end
            if (act_data_vld[9] && act_data_req[9]) consumed.push_back(act_data_out);
            if (act_in_vld && act_in_rdy) idx++;
            tick();
        end
        act_in_vld = 1'b0; act_data_req = '0;
        check_eq("act_sent", 64'(idx), 64'd6);
        check_eq("act_consumed_cnt", 64'(consumed.size()), 64'd6);
        for (int i = 0; i < consumed.size() && i < 6; i++) begin
            check_eq($sformatf("act_seq_%0d", i), 64'(consumed[i]), 64'(beat(i)));
        end

        // Out-of-range instruction tag
        inst_in_row = 4'd13; inst_in_bcast = 1'b0; inst_in_data = 14'h1FF; inst_in_vld = 1'b1;
        #1;
        check_eq("err_rdy", 64'(inst_in_rdy), 64'h1);
        check_eq("err_pre", 64'(err_row), 64'h0);
        tick();
        inst_in_vld = 1'b0;
        check_eq("err_set", 64'(err_row), 64'h1);
        repeat (3) tick();
        check_eq("err_sticky", 64'(err_row), 64'h1);
        check_eq("err_no_en", 64'(inst_en), 64'h0);
        check_eq("err_idle", 64'(row_idle), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("err_cleared", 64'(err_row), 64'h0);

        // Out-of-range activation tag
        act_in_row = 4'd14; act_in_data = 32'hDEAD_BEEF; act_in_vld = 1'b1;
        #1;
        check_eq("act_err_rdy", 64'(act_in_rdy), 64'h1);
        tick();
        act_in_vld = 1'b0;
        check_eq("act_err_set", 64'(err_row), 64'h1);
        check_eq("act_err_vld", 64'(act_data_vld), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
